psum_drain: RTL

- Sits below the bottom PE row of the weight-stationary systolic array and collects partial sums as they leave each column.
- The array emits column c's result for vector m COL_SKEW*c cycles later than column 0's result.
- This block deskews those results into one aligned row vector per input vector and buffers them in a FIFO.
- It presents the vectors to the output buffer writer over a valid/ready handshake, and flags a sticky overflow because the array cannot stall.

---
 rtl/psum_drain_if.sv | 28 ++
 rtl/psum_drain.sv | 128 ++++++++++++
 2 files changed

// File: rtl/psum_drain_if.sv
// Handshake and data bundle between the systolic array bottom row, the
// partial-sum drain, and the output buffer writer.
interface psum_drain_if #(
    parameter int COLS   = 4,
    parameter int PSUM_W = 32,
    parameter int CNT_W  = 16
);
    logic                   in_start;
    logic [CNT_W-1:0]       in_num_vec;
    logic [COLS*PSUM_W-1:0] in_psum;
    logic                   out_valid;
    logic                   out_ready;
    logic [COLS*PSUM_W-1:0] out_data;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   ovf_err;

    modport slave (
        input  in_start, in_num_vec, in_psum, out_ready,
        output out_valid, out_data, out_last, busy, done, ovf_err
    );

    modport master (
        output in_start, in_num_vec, in_psum, out_ready,
        input  out_valid, out_data, out_last, busy, done, ovf_err
    );
endinterface

// File: rtl/psum_drain.sv
// Deskews per-column partial sums leaving the array into aligned row vectors,
// buffers them in a FIFO and hands them out over valid/ready.
module psum_drain #(
    parameter int COLS       = 4,
    parameter int PSUM_W     = 32,
    parameter int COL_SKEW   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    psum_drain_if.slave  bus
);
    localparam int TOTAL = (COLS - 1) * COL_SKEW;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int W     = COLS * PSUM_W;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             ovf_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [W-1:0]     mem_q  [FIFO_DEPTH];
    logic             last_q [FIFO_DEPTH];

    logic [W-1:0]  aligned_d;
    logic          push_d, push_last_d, pop_d, wr_en_d, drop_d, full_d, empty_d;
    logic [AW-1:0] newest_d;

    // Column c waits (COLS-1-c)*COL_SKEW cycles so every column lines up with the last one.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = (COLS - 1 - c) * COL_SKEW;
        if (D == 0) begin : g_pass
            assign aligned_d[c*PSUM_W +: PSUM_W] = bus.in_psum[c*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [PSUM_W-1:0] dl_q [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < D; i++) dl_q[i] <= '0;
                end else begin
                    dl_q[0] <= bus.in_psum[c*PSUM_W +: PSUM_W];
                    for (int i = 1; i < D; i++) dl_q[i] <= dl_q[i-1];
                end
            end
            assign aligned_d[c*PSUM_W +: PSUM_W] = dl_q[D-1];
        end
    end

    assign empty_d     = (cnt_q == '0);
    assign full_d      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop_d       = !empty_d && bus.out_ready;
    assign push_d      = (state_q == DRAIN) && (wait_q == '0);
    assign push_last_d = push_d && (rem_q == CNT_W'(1));
    assign wr_en_d     = push_d && (!full_d || pop_d);
    assign drop_d      = push_d && full_d && !pop_d;
    assign newest_d    = wr_ptr_q - AW'(1);

    // The wait count is one short of TOTAL because the IDLE->DRAIN cycle is itself one skew step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) last_q[i] <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.in_start) begin
                    if (bus.in_num_vec == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        rem_q   <= bus.in_num_vec;
                        wait_q  <= CNT_W'(TOTAL - 1);
                        ovf_q   <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - CNT_W'(1);
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) state_q <= FLUSH;
                    end
                end
                FLUSH: if (pop_d && last_q[rd_ptr_q]) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (wr_en_d) begin
                last_q[wr_ptr_q] <= push_last_d;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            // A dropped final vector moves its tag onto the newest stored entry so FLUSH ends.
            if (drop_d) begin
                ovf_q <= 1'b1;
                if (push_last_d) last_q[newest_d] <= 1'b1;
            end
            if (pop_d) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en_d && !pop_d)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (!wr_en_d && pop_d) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) mem_q[wr_ptr_q] <= aligned_d;
    end

    assign bus.out_valid = !empty_d;
    assign bus.out_data  = empty_d ? '0 : mem_q[rd_ptr_q];
    assign bus.out_last  = !empty_d && last_q[rd_ptr_q];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.ovf_err   = ovf_q;
endmodule
